lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu.sv | 175 +++++++++++++++++
 tb/tb_lsu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared core definitions for the load/store unit: funct3 size encodings,
// exception causes and size/alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    EXC_LD_MISALIGN  = 2'd0,
    EXC_ST_MISALIGN  = 2'd1,
    EXC_ACCESS_FAULT = 2'd2,
    EXC_TIMEOUT      = 2'd3
  } exc_cause_e;

  // Any encoding other than byte/half (011, 110, 111 included) is a word.
  function automatic lsu_size_e lsu_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (lsu_size(f3))
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / data replication and
// load data shift with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_sh;
  logic        w_sext;

  assign w_sh   = i_ld_rdata >> {i_ld_off, 3'b000};
  assign w_sext = ~i_ld_funct3[2];

  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      SZ_B: begin
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_H: begin
        o_st_be    = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld_data = w_sh;
    case (lsu_size(i_ld_funct3))
      SZ_B:    o_ld_data = {{24{w_sext & w_sh[7]}}, w_sh[7:0]};
      SZ_H:    o_ld_data = {{16{w_sext & w_sh[15]}}, w_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit with bus timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead
// of silently aligning them.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        exc_valid_o,
  output logic [1:0]  exc_cause_o
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_exc_valid;
  exc_cause_e  r_exc_cause;

  lsu_size_e   w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;

  assign w_size = lsu_size(req_funct3_i);

  // Offending low bits are dropped so the access lands on its natural boundary.
  always_comb begin
    w_off = req_addr_i[1:0];
    case (w_size)
      SZ_H:    w_off = {req_addr_i[1], 1'b0};
      SZ_W:    w_off = 2'b00;
      default: ;
    endcase
  end

  lsu_align u_align (
    .i_st_size   (w_size),
    .i_st_off    (w_off),
    .i_st_wdata  (req_wdata_i),
    .o_st_be     (w_be),
    .o_st_wdata  (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_ld_rdata  (mem_rdata_i),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= EXC_LD_MISALIGN;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_off       <= w_off;
            r_funct3    <= req_funct3_i;
            r_rd        <= req_rd_i;
            r_mem_addr  <= {req_addr_i[31:2], 2'b00};
            r_mem_we    <= req_we_i;
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
            if (lsu_misaligned(req_funct3_i, req_addr_i[1:0])) begin
              r_state     <= S_DONE;
              r_exc_valid <= 1'b1;
              r_exc_cause <= req_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            end else begin
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
            end
`else
            r_state   <= S_REQ;
            r_mem_req <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            r_state <= S_DONE;
            if (mem_err_i) begin
              r_exc_valid <= 1'b1;
              r_exc_cause <= EXC_ACCESS_FAULT;
            end else if (!r_mem_we) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_ld_data;
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state     <= S_DONE;
            r_exc_valid <= 1'b1;
            r_exc_cause <= EXC_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_wb_valid  <= 1'b0;
          r_exc_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_mem_addr;
  assign mem_we_o    = r_mem_we;
  assign mem_be_o    = r_mem_be;
  assign mem_wdata_o = r_mem_wdata;
  assign wb_valid_o  = r_wb_valid;
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
  assign exc_valid_o = r_exc_valid;
  assign exc_cause_o = r_exc_cause;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected bus requests and
// writeback/exception pulses; a negedge monitor pops and compares them.
module tb_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic [4:0]  req_rd_i;
  logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        wb_valid_o, exc_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [1:0]  exc_cause_o;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_rd_i(req_rd_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 1 writeback, 2 exception
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
  } ev_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  ev_t  evq[$];
  bus_t busq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pulses against the event queue, bus requests against the bus queue.
  always @(negedge clk) begin
    ev_t  e;
    bus_t b;
    if (!rst) begin
      if (wb_valid_o || exc_valid_o) begin
        chk("wb_exc_exclusive", {31'd0, wb_valid_o & exc_valid_o}, 32'd0);
        if (evq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_pulse actual wb=%0b exc=%0b required none (cycle %0d)",
                   wb_valid_o, exc_valid_o, cyc);
        end else begin
          e = evq.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_is_wb", {31'd0, wb_valid_o}, {31'd0, e.kind == 1});
          if (e.kind == 1) begin
            chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
            chk("wb_data", wb_data_o, e.data);
          end else begin
            chk("exc_cause", {30'd0, exc_cause_o}, {30'd0, e.cause});
          end
        end
      end else if (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        n_vec++;
        n_miss++;
        $display("FAIL missing_pulse actual none required kind=%0d at cycle %0d", e.kind, e.cyc);
      end

      if (mem_req_o) begin
        if (busq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_mem_req actual addr=%h required no request (cycle %0d)",
                   mem_addr_o, cyc);
        end else begin
          b = busq[0];
          chk("mem_addr", mem_addr_o, b.addr);
          chk("mem_be", {28'd0, mem_be_o}, {28'd0, b.be});
          chk("mem_wdata", mem_wdata_o, b.wdata);
          chk("mem_we", {31'd0, mem_we_o}, {31'd0, b.we});
          if (mem_gnt_i) void'(busq.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rvd < 0 means the response never comes; a late rvalid is then sent in IDLE.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int gd, input int rvd, input logic [31:0] rdata, input logic err,
                        input int ekind, input logic [31:0] edata, input logic [1:0] ecause,
                        input logic [31:0] baddr, input logic [3:0] bbe,
                        input logic [31:0] bwdata, input logic trap);
    ev_t  e;
    bus_t b;
    int   c1;
    chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_rd_i     = rd;
    step();
    req_valid_i = 1'b0;
    c1 = cyc;
    e.kind = ekind;
    e.rd = rd;
    e.data = edata;
    e.cause = ecause;
    if (trap) begin
      e.cyc = c1;
      evq.push_back(e);
      step();
    end else begin
      b.addr = baddr;
      b.be = bbe;
      b.wdata = bwdata;
      b.we = we;
      busq.push_back(b);
      if (ekind != 0) begin
        e.cyc = (rvd < 0) ? c1 + gd + 1 + TO : c1 + gd + 2 + rvd;
        evq.push_back(e);
      end
      repeat (gd) step();
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      if (rvd < 0) begin
        repeat (TO + 1) step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        step();
        mem_rvalid_i = 1'b0;
        step();
      end else begin
        repeat (rvd) step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        mem_err_i    = err;
        step();
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        step();
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid_o}, 32'd0);
    chk("rst_exc_cause", {30'd0, exc_cause_o}, 32'd0);
    step();

    // LB / LBU at 0x1003, zero-wait bus
    access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 0, 0, 32'h80FF_FF11, 1'b0,
           1, 32'hFFFF_FF80, 2'd0, 32'h0000_1000, 4'b1000, 32'h0, 1'b0);
    access(1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd6, 0, 0, 32'h80FF_FF11, 1'b0,
           1, 32'h0000_0080, 2'd0, 32'h0000_1000, 4'b1000, 32'h0, 1'b0);
    // SH at 0x2002
    access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 0, 0, 32'h0, 1'b0,
           0, 32'h0, 2'd0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd7, 0, 0, 32'hDEAD_BEEF, 1'b0,
           2, 32'h0, 2'd0, 32'h0, 4'b0, 32'h0, 1'b1);
    access(1'b1, 3'b010, 32'h0000_5002, 32'h1122_3344, 5'd0, 0, 0, 32'h0, 1'b0,
           2, 32'h0, 2'd1, 32'h0, 4'b0, 32'h0, 1'b1);
    access(1'b0, 3'b001, 32'h0000_4003, 32'h0, 5'd13, 0, 0, 32'h7FFF_0000, 1'b0,
           2, 32'h0, 2'd0, 32'h0, 4'b0, 32'h0, 1'b1);
`else
    access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd7, 0, 0, 32'hDEAD_BEEF, 1'b0,
           1, 32'hDEAD_BEEF, 2'd0, 32'h0000_3000, 4'b1111, 32'h0, 1'b0);
    access(1'b1, 3'b010, 32'h0000_5002, 32'h1122_3344, 5'd0, 0, 0, 32'h0, 1'b0,
           0, 32'h0, 2'd0, 32'h0000_5000, 4'b1111, 32'h1122_3344, 1'b0);
    access(1'b0, 3'b001, 32'h0000_4003, 32'h0, 5'd13, 0, 0, 32'h7FFF_0000, 1'b0,
           1, 32'h0000_7FFF, 2'd0, 32'h0000_4000, 4'b1100, 32'h0, 1'b0);
`endif
    // LH / LHU with bus wait states
    access(1'b0, 3'b001, 32'h0000_4002, 32'h0, 5'd8, 2, 1, 32'h8001_1234, 1'b0,
           1, 32'hFFFF_8001, 2'd0, 32'h0000_4000, 4'b1100, 32'h0, 1'b0);
    access(1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd9, 0, 0, 32'h8001_1234, 1'b0,
           1, 32'h0000_8001, 2'd0, 32'h0000_4000, 4'b1100, 32'h0, 1'b0);
    // SB at 0x7001
    access(1'b1, 3'b000, 32'h0000_7001, 32'h0000_00EF, 5'd0, 1, 2, 32'h0, 1'b0,
           0, 32'h0, 2'd0, 32'h0000_7000, 4'b0010, 32'hEFEF_EFEF, 1'b0);
    // Reserved funct3 encodings behave as word
    access(1'b0, 3'b011, 32'h0000_6000, 32'h0, 5'd10, 0, 0, 32'h0123_4567, 1'b0,
           1, 32'h0123_4567, 2'd0, 32'h0000_6000, 4'b1111, 32'h0, 1'b0);
    access(1'b0, 3'b110, 32'h0000_6004, 32'h0, 5'd11, 0, 0, 32'h89AB_CDEF, 1'b0,
           1, 32'h89AB_CDEF, 2'd0, 32'h0000_6004, 4'b1111, 32'h0, 1'b0);
    // Access fault
    access(1'b0, 3'b010, 32'h0000_6008, 32'h0, 5'd12, 0, 1, 32'h5555_5555, 1'b1,
           2, 32'h0, 2'd2, 32'h0000_6008, 4'b1111, 32'h0, 1'b0);
    // Timeout with delayed grant, then a late rvalid in IDLE
    access(1'b0, 3'b010, 32'h0000_8000, 32'h0, 5'd14, 3, -1, 32'h1111_1111, 1'b0,
           2, 32'h0, 2'd3, 32'h0000_8000, 4'b1111, 32'h0, 1'b0);

    // Reset while in WAIT, then a stray rvalid
    begin
      bus_t b;
      chk("ready_before_abort", {31'd0, req_ready_o}, 32'd1);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
      req_addr_i = 32'h0000_9100; req_wdata_i = 32'h0; req_rd_i = 5'd3;
      step();
      req_valid_i = 1'b0;
      b.addr = 32'h0000_9100; b.be = 4'b1111; b.wdata = 32'h0; b.we = 1'b0;
      busq.push_back(b);
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h7777_7777;
      step();
      mem_rvalid_i = 1'b0;
      step();
      chk("abort_ready", {31'd0, req_ready_o}, 32'd1);
      chk("abort_mem_req", {31'd0, mem_req_o}, 32'd0);
    end
    access(1'b0, 3'b010, 32'h0000_9000, 32'h0, 5'd4, 0, 0, 32'hCAFE_F00D, 1'b0,
           1, 32'hCAFE_F00D, 2'd0, 32'h0000_9000, 4'b1111, 32'h0, 1'b0);

    repeat (4) step();
    chk("events_drained", evq.size(), 32'd0);
    chk("bus_drained", busq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
